// File: rtl/load_store_buffer_pkg.sv
// Shared constants, op encodings and entry layout for the load/store buffer.
// Also holds the helpers for op decoding and operand snooping.
package load_store_buffer_pkg;
  localparam int LSB_SIZE = 16;
  localparam int LSB_W    = 4;
  localparam int ROB_W    = 4;
  localparam int OP_W     = 6;
  localparam int DATA_W   = 32;

  localparam logic [OP_W-1:0] OP_LB  = 6'd1;
  localparam logic [OP_W-1:0] OP_LH  = 6'd2;
  localparam logic [OP_W-1:0] OP_LW  = 6'd3;
  localparam logic [OP_W-1:0] OP_LBU = 6'd4;
  localparam logic [OP_W-1:0] OP_LHU = 6'd5;
  localparam logic [OP_W-1:0] OP_SB  = 6'd6;
  localparam logic [OP_W-1:0] OP_SH  = 6'd7;
  localparam logic [OP_W-1:0] OP_SW  = 6'd8;

  localparam logic [LSB_W-1:0] IDX_ONE    = 1;
  localparam logic [LSB_W:0]   CNT_ONE    = 1;
  localparam logic [LSB_W:0]   CNT_FULL   = LSB_SIZE[LSB_W:0];
  localparam logic [LSB_W:0]   CNT_ALMOST = CNT_FULL - CNT_ONE;

  typedef enum logic {S_IDLE, S_WAIT_MEM} lsb_state_t;

  typedef struct packed {
    logic              ok;
    logic [DATA_W-1:0] val;
  } operand_t;

  typedef struct packed {
    logic              valid;
    logic              committed;
    logic [OP_W-1:0]   op;
    operand_t          rs1;
    logic [ROB_W-1:0]  rs1_rob;
    operand_t          rs2;
    logic [ROB_W-1:0]  rs2_rob;
    logic [DATA_W-1:0] imm;
    logic [ROB_W-1:0]  robpos;
  } lsb_entry_t;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] mem_len_of(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd3;
    endcase
  endfunction

  // ALU result wins over the LSB self-broadcast if both carry the same tag.
  function automatic operand_t snoop_operand(
    input operand_t          cur,
    input logic [ROB_W-1:0]  tag,
    input logic              a_flag,
    input logic [DATA_W-1:0] a_val,
    input logic [ROB_W-1:0]  a_tag,
    input logic              l_flag,
    input logic [DATA_W-1:0] l_val,
    input logic [ROB_W-1:0]  l_tag
  );
    operand_t res;
    res = cur;
    if (!cur.ok) begin
      if (a_flag && (a_tag == tag)) begin
        res.ok  = 1'b1;
        res.val = a_val;
      end else if (l_flag && (l_tag == tag)) begin
        res.ok  = 1'b1;
        res.val = l_val;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Turns raw low-aligned memory data into the architectural load value.
// Purely combinational so an MMIO read path can share it.
module load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_val
);
  always_comb begin
    case (i_op)
      OP_LB:   o_val = {{24{i_raw[7]}}, i_raw[7:0]};
      OP_LH:   o_val = {{16{i_raw[15]}}, i_raw[15:0]};
      OP_LBU:  o_val = {24'd0, i_raw[7:0]};
      OP_LHU:  o_val = {16'd0, i_raw[15:0]};
      default: o_val = i_raw;
    endcase
  end
endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: loads launch at the head when addressable,
// stores only after ROB commit; committed stores survive a pipeline clear.
module load_store_buffer
  import load_store_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              clear,
  output logic              lsb_full,
  output logic [LSB_W-1:0]  lsb_tail,
  input  logic              push,
  input  logic [OP_W-1:0]   push_op,
  input  logic              push_rs1_ok,
  input  logic [DATA_W-1:0] push_rs1_val,
  input  logic [ROB_W-1:0]  push_rs1_rob,
  input  logic              push_rs2_ok,
  input  logic [DATA_W-1:0] push_rs2_val,
  input  logic [ROB_W-1:0]  push_rs2_rob,
  input  logic [DATA_W-1:0] push_imm,
  input  logic [ROB_W-1:0]  push_robpos,
  input  logic              alu_flag,
  input  logic [DATA_W-1:0] alu_val,
  input  logic [ROB_W-1:0]  alu_robpos,
  input  logic              rob_store_flag,
  input  logic [LSB_W-1:0]  rob_store_lsbpos,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_len,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lsb_out_flag,
  output logic [DATA_W-1:0] lsb_out_val,
  output logic [ROB_W-1:0]  lsb_out_robpos
);
  lsb_entry_t        r_entry [LSB_SIZE];
  lsb_entry_t        w_entry_next [LSB_SIZE];
  logic [LSB_W-1:0]  r_head, r_tail, r_last_commit;
  logic [LSB_W:0]    r_count;
  lsb_state_t        r_state, w_state_next;

  logic              r_mem_req, r_mem_wr;
  logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;
  logic [1:0]        r_mem_len;
  logic              r_out_flag;
  logic [DATA_W-1:0] r_out_val;
  logic [ROB_W-1:0]  r_out_robpos;

  lsb_entry_t        w_head_entry, w_push_entry;
  logic              w_head_store, w_head_ready;
  logic              w_launch, w_pop, w_abandon, w_push_ok, w_any_commit;
  logic [LSB_W-1:0]  w_head_next, w_tail_next, w_last_commit_next, w_clear_tail;
  logic [LSB_W:0]    w_count_next;
  logic [DATA_W-1:0] w_ext_val;

  assign w_head_entry = r_entry[r_head];
  assign w_head_store = is_store(w_head_entry.op);
  assign w_head_ready = w_head_entry.valid && w_head_entry.rs1.ok &&
                        (!w_head_store || (w_head_entry.committed && w_head_entry.rs2.ok));

  load_extend u_load_extend (
    .i_op  (w_head_entry.op),
    .i_raw (mem_rdata),
    .o_val (w_ext_val)
  );

  always_ff @(posedge clk) begin
    if (reset)      r_state <= S_IDLE;
    else if (ready) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_launch) w_state_next = S_WAIT_MEM;
      S_WAIT_MEM: if (w_abandon || w_pop) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // An uncommitted load must not launch into a clear; a committed store may.
  always_comb begin
    w_launch  = ready && (r_state == S_IDLE) && w_head_ready && (w_head_store || !clear);
    w_abandon = ready && (r_state == S_WAIT_MEM) && clear && !w_head_store;
    w_pop     = ready && (r_state == S_WAIT_MEM) && mem_done && !w_abandon;
    w_push_ok = ready && push && !clear && (r_count != CNT_FULL);
  end

  always_comb begin
    w_push_entry           = '0;
    w_push_entry.valid     = 1'b1;
    w_push_entry.op        = push_op;
    w_push_entry.rs1_rob   = push_rs1_rob;
    w_push_entry.rs2_rob   = push_rs2_rob;
    w_push_entry.imm       = push_imm;
    w_push_entry.robpos    = push_robpos;
    w_push_entry.rs1       = snoop_operand('{ok: push_rs1_ok, val: push_rs1_val}, push_rs1_rob,
                                           alu_flag, alu_val, alu_robpos,
                                           r_out_flag, r_out_val, r_out_robpos);
    w_push_entry.rs2       = snoop_operand('{ok: push_rs2_ok, val: push_rs2_val}, push_rs2_rob,
                                           alu_flag, alu_val, alu_robpos,
                                           r_out_flag, r_out_val, r_out_robpos);
  end

  always_comb begin
    w_any_commit = 1'b0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      w_entry_next[i] = r_entry[i];
      if (r_entry[i].valid) begin
        w_entry_next[i].rs1 = snoop_operand(r_entry[i].rs1, r_entry[i].rs1_rob,
                                            alu_flag, alu_val, alu_robpos,
                                            r_out_flag, r_out_val, r_out_robpos);
        w_entry_next[i].rs2 = snoop_operand(r_entry[i].rs2, r_entry[i].rs2_rob,
                                            alu_flag, alu_val, alu_robpos,
                                            r_out_flag, r_out_val, r_out_robpos);
        if (rob_store_flag && (rob_store_lsbpos == LSB_W'(i)))
          w_entry_next[i].committed = 1'b1;
      end
      if (w_pop && (r_head == LSB_W'(i))) begin
        w_entry_next[i].valid     = 1'b0;
        w_entry_next[i].committed = 1'b0;
      end
      if (clear && !w_entry_next[i].committed)
        w_entry_next[i].valid = 1'b0;
      w_any_commit = w_any_commit || (w_entry_next[i].valid && w_entry_next[i].committed);
      if (w_push_ok && (r_tail == LSB_W'(i)))
        w_entry_next[i] = w_push_entry;
    end
  end

  always_comb begin
    w_last_commit_next = rob_store_flag ? rob_store_lsbpos : r_last_commit;
    w_head_next        = w_pop ? r_head + IDX_ONE : r_head;
    w_clear_tail       = w_any_commit ? w_last_commit_next + IDX_ONE : w_head_next;
    if (clear) begin
      w_tail_next = w_clear_tail;
      if (!w_any_commit)                     w_count_next = '0;
      else if (w_clear_tail == w_head_next)  w_count_next = CNT_FULL;
      else                                   w_count_next = {1'b0, w_clear_tail - w_head_next};
    end else begin
      w_tail_next  = w_push_ok ? r_tail + IDX_ONE : r_tail;
      w_count_next = r_count + (w_push_ok ? CNT_ONE : '0) - (w_pop ? CNT_ONE : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LSB_SIZE; i++) r_entry[i] <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_last_commit <= '0;
      r_count       <= '0;
      r_mem_req     <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_len     <= '0;
      r_out_flag    <= 1'b0;
      r_out_val     <= '0;
      r_out_robpos  <= '0;
    end else begin
      r_out_flag <= 1'b0;
      if (ready) begin
        for (int i = 0; i < LSB_SIZE; i++) r_entry[i] <= w_entry_next[i];
        r_head        <= w_head_next;
        r_tail        <= w_tail_next;
        r_last_commit <= w_last_commit_next;
        r_count       <= w_count_next;
        if (w_launch) begin
          r_mem_req   <= 1'b1;
          r_mem_wr    <= w_head_store;
          r_mem_addr  <= w_head_entry.rs1.val + w_head_entry.imm;
          r_mem_wdata <= w_head_entry.rs2.val;
          r_mem_len   <= mem_len_of(w_head_entry.op);
        end else if (w_pop || w_abandon) begin
          r_mem_req <= 1'b0;
        end
        if (w_pop && !w_head_store) begin
          r_out_flag   <= 1'b1;
          r_out_val    <= w_ext_val;
          r_out_robpos <= w_head_entry.robpos;
        end
      end
    end
  end

  assign lsb_full       = (r_count >= CNT_ALMOST);
  assign lsb_tail       = r_tail;
  assign mem_req        = r_mem_req;
  assign mem_wr         = r_mem_wr;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_len        = r_mem_len;
  assign lsb_out_flag   = r_out_flag;
  assign lsb_out_val    = r_out_val;
  assign lsb_out_robpos = r_out_robpos;
endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: table of load vectors plus
// hand-written store, clear, full/wrap and abandon sequences.
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              reset, ready, clear, lsb_full;
  logic [LSB_W-1:0]  lsb_tail;
  logic              push;
  logic [OP_W-1:0]   push_op;
  logic              push_rs1_ok, push_rs2_ok;
  logic [31:0]       push_rs1_val, push_rs2_val, push_imm;
  logic [ROB_W-1:0]  push_rs1_rob, push_rs2_rob, push_robpos;
  logic              alu_flag;
  logic [31:0]       alu_val;
  logic [ROB_W-1:0]  alu_robpos;
  logic              rob_store_flag;
  logic [LSB_W-1:0]  rob_store_lsbpos;
  logic              mem_req, mem_wr, mem_done;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [1:0]        mem_len;
  logic              lsb_out_flag;
  logic [31:0]       lsb_out_val;
  logic [ROB_W-1:0]  lsb_out_robpos;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_buffer dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .lsb_full(lsb_full), .lsb_tail(lsb_tail),
    .push(push), .push_op(push_op),
    .push_rs1_ok(push_rs1_ok), .push_rs1_val(push_rs1_val), .push_rs1_rob(push_rs1_rob),
    .push_rs2_ok(push_rs2_ok), .push_rs2_val(push_rs2_val), .push_rs2_rob(push_rs2_rob),
    .push_imm(push_imm), .push_robpos(push_robpos),
    .alu_flag(alu_flag), .alu_val(alu_val), .alu_robpos(alu_robpos),
    .rob_store_flag(rob_store_flag), .rob_store_lsbpos(rob_store_lsbpos),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .lsb_out_flag(lsb_out_flag), .lsb_out_val(lsb_out_val), .lsb_out_robpos(lsb_out_robpos)
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      rs1;
    logic [31:0]      imm;
    logic [31:0]      rdata;
    logic [ROB_W-1:0] robpos;
    logic [31:0]      exp_addr;
    logic [1:0]       exp_len;
    logic [31:0]      exp_val;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ready = 1'b1; clear = 1'b0; push = 1'b0; push_op = '0;
    push_rs1_ok = 1'b0; push_rs1_val = '0; push_rs1_rob = '0;
    push_rs2_ok = 1'b0; push_rs2_val = '0; push_rs2_rob = '0;
    push_imm = '0; push_robpos = '0;
    alu_flag = 1'b0; alu_val = '0; alu_robpos = '0;
    rob_store_flag = 1'b0; rob_store_lsbpos = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_entry(input logic [OP_W-1:0] op,
                            input logic r1ok, input logic [31:0] r1v, input logic [ROB_W-1:0] r1r,
                            input logic r2ok, input logic [31:0] r2v, input logic [ROB_W-1:0] r2r,
                            input logic [31:0] imm, input logic [ROB_W-1:0] rp);
    push = 1'b1; push_op = op;
    push_rs1_ok = r1ok; push_rs1_val = r1v; push_rs1_rob = r1r;
    push_rs2_ok = r2ok; push_rs2_val = r2v; push_rs2_rob = r2r;
    push_imm = imm; push_robpos = rp;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'd0, mem_req}, 32'd1);
  endtask

  task automatic mem_complete(input logic [31:0] rdata);
    mem_done = 1'b1; mem_rdata = rdata;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    logic [LSB_W-1:0] exp_tail;

    vecs[0] = '{OP_LW,  32'h0000_0100, 32'h0000_0004, 32'hDEAD_BEEF, 4'd1, 32'h0000_0104, 2'd3, 32'hDEAD_BEEF};
    vecs[1] = '{OP_LB,  32'h0000_0000, 32'h0000_0010, 32'h0000_0080, 4'd2, 32'h0000_0010, 2'd0, 32'hFFFF_FF80};
    vecs[2] = '{OP_LBU, 32'h0000_0000, 32'h0000_0010, 32'h0000_0080, 4'd3, 32'h0000_0010, 2'd0, 32'h0000_0080};
    vecs[3] = '{OP_LH,  32'h0000_2000, 32'h0000_0002, 32'h0000_8000, 4'd4, 32'h0000_2002, 2'd1, 32'hFFFF_8000};
    vecs[4] = '{OP_LHU, 32'h0000_2000, 32'h0000_0002, 32'h1234_F00F, 4'd5, 32'h0000_2002, 2'd1, 32'h0000_F00F};
    vecs[5] = '{OP_LB,  32'hFFFF_FFFC, 32'h0000_0008, 32'hAABB_CC7F, 4'd6, 32'h0000_0004, 2'd0, 32'h0000_007F};
    vecs[6] = '{OP_LW,  32'h0000_0200, 32'hFFFF_FFF0, 32'h0000_0000, 4'd7, 32'h0000_01F0, 2'd3, 32'h0000_0000};
    vecs[7] = '{OP_LH,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_7FFF, 4'd8, 32'h0000_0000, 2'd1, 32'h0000_7FFF};

    do_reset();
    check("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    check("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
    check("rst_out_flag", {31'd0, lsb_out_flag}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_val",  lsb_out_val, 32'd0);
    check("rst_mem_len",  {30'd0, mem_len}, 32'd0);
    check("rst_tail",     {28'd0, lsb_tail}, 32'd0);
    check("rst_full",     {31'd0, lsb_full}, 32'd0);

    // Table-driven loads, one at a time through the head.
    exp_tail = '0;
    for (int i = 0; i < 8; i++) begin
      push_entry(vecs[i].op, 1'b1, vecs[i].rs1, 4'd0, 1'b0, 32'd0, 4'd0, vecs[i].imm, vecs[i].robpos);
      exp_tail = exp_tail + 4'd1;
      check("vec_tail", {28'd0, lsb_tail}, {28'd0, exp_tail});
      wait_req("vec_req");
      check("vec_addr", mem_addr, vecs[i].exp_addr);
      check("vec_len",  {30'd0, mem_len}, {30'd0, vecs[i].exp_len});
      check("vec_wr",   {31'd0, mem_wr}, 32'd0);
      repeat (3) tick();
      check("vec_req_hold", {31'd0, mem_req}, 32'd1);
      mem_complete(vecs[i].rdata);
      check("vec_out_flag",   {31'd0, lsb_out_flag}, 32'd1);
      check("vec_out_val",    lsb_out_val, vecs[i].exp_val);
      check("vec_out_robpos", {28'd0, lsb_out_robpos}, {28'd0, vecs[i].robpos});
      check("vec_req_drop",   {31'd0, mem_req}, 32'd0);
      tick();
      check("vec_out_pulse",  {31'd0, lsb_out_flag}, 32'd0);
      $display("vec %0d op=%0d addr=0x%08h val=0x%08h rob=%0d", i, vecs[i].op, mem_addr, lsb_out_val, lsb_out_robpos);
    end

    // Store waits for both commit and its pending rs2 operand.
    do_reset();
    push_entry(OP_SW, 1'b1, 32'h0000_0300, 4'd0, 1'b0, 32'd0, 4'd5, 32'd0, 4'd2);
    check("st_tail", {28'd0, lsb_tail}, 32'd1);
    repeat (4) tick();
    check("st_no_req_uncommitted", {31'd0, mem_req}, 32'd0);
    rob_store_flag = 1'b1; rob_store_lsbpos = 4'd0;
    tick();
    rob_store_flag = 1'b0;
    repeat (3) tick();
    check("st_no_req_rs2_pending", {31'd0, mem_req}, 32'd0);
    alu_flag = 1'b1; alu_robpos = 4'd5; alu_val = 32'h55;
    tick();
    alu_flag = 1'b0;
    wait_req("st_req");
    check("st_wr",    {31'd0, mem_wr}, 32'd1);
    check("st_wdata", mem_wdata, 32'h55);
    check("st_addr",  mem_addr, 32'h300);
    check("st_len",   {30'd0, mem_len}, 32'd3);
    mem_complete(32'd0);
    check("st_no_out", {31'd0, lsb_out_flag}, 32'd0);
    $display("store addr=0x%08h wdata=0x%08h", mem_addr, mem_wdata);

    // Operand captured from an ALU broadcast in the push cycle; ready low holds.
    do_reset();
    ready = 1'b0;
    push_entry(OP_LW, 1'b1, 32'h0, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd1);
    ready = 1'b1;
    check("ready_low_tail", {28'd0, lsb_tail}, 32'd0);
    check("ready_low_req",  {31'd0, mem_req}, 32'd0);
    alu_flag = 1'b1; alu_robpos = 4'd3; alu_val = 32'h400;
    push_entry(OP_LW, 1'b0, 32'd0, 4'd3, 1'b0, 32'd0, 4'd0, 32'h10, 4'd9);
    alu_flag = 1'b0;
    wait_req("snoop_req");
    check("snoop_addr", mem_addr, 32'h410);
    mem_complete(32'h1111_2222);
    check("snoop_out_robpos", {28'd0, lsb_out_robpos}, 32'd9);
    $display("push-snoop addr=0x%08h", mem_addr);

    // Clear keeps a committed store, flushes the loads behind it.
    do_reset();
    push_entry(OP_SW, 1'b1, 32'h500, 4'd0, 1'b1, 32'h77, 4'd0, 32'd0, 4'd1);
    push_entry(OP_LW, 1'b1, 32'h600, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd2);
    push_entry(OP_LW, 1'b1, 32'h700, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd3);
    tick(); tick();
    check("clr_wait_commit", {31'd0, mem_req}, 32'd0);
    rob_store_flag = 1'b1; rob_store_lsbpos = 4'd0;
    tick();
    rob_store_flag = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_tail",  {28'd0, lsb_tail}, 32'd1);
    check("clr_req",   {31'd0, mem_req}, 32'd1);
    check("clr_wr",    {31'd0, mem_wr}, 32'd1);
    check("clr_addr",  mem_addr, 32'h500);
    check("clr_wdata", mem_wdata, 32'h77);
    mem_complete(32'd0);
    check("clr_req_drop", {31'd0, mem_req}, 32'd0);
    repeat (5) tick();
    check("clr_loads_gone", {31'd0, mem_req}, 32'd0);
    check("clr_no_out",     {31'd0, lsb_out_flag}, 32'd0);
    push_entry(OP_LW, 1'b1, 32'h800, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd4);
    check("clr_tail_after", {28'd0, lsb_tail}, 32'd2);
    wait_req("clr_next_req");
    check("clr_next_addr", mem_addr, 32'h800);
    mem_complete(32'h1234);
    check("clr_next_val",    lsb_out_val, 32'h1234);
    check("clr_next_robpos", {28'd0, lsb_out_robpos}, 32'd4);
    $display("clear-keep-store tail=%0d", lsb_tail);

    // Fill to 15, pop one, wrap the tail, then overflow drops a push.
    do_reset();
    push_entry(OP_LW, 1'b1, 32'h40, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd2);
    for (int i = 1; i < 14; i++)
      push_entry(OP_LW, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd0, 4'd10);
    check("fill14_full", {31'd0, lsb_full}, 32'd0);
    push_entry(OP_LW, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd0, 4'd10);
    check("fill15_full", {31'd0, lsb_full}, 32'd1);
    check("fill15_tail", {28'd0, lsb_tail}, 32'd15);
    check("fill_head_req", {31'd0, mem_req}, 32'd1);
    mem_complete(32'd0);
    check("pop_full", {31'd0, lsb_full}, 32'd0);
    push_entry(OP_LW, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd0, 4'd10);
    check("wrap_tail", {28'd0, lsb_tail}, 32'd0);
    check("wrap_full", {31'd0, lsb_full}, 32'd1);
    push_entry(OP_LW, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd0, 4'd10);
    check("to16_tail", {28'd0, lsb_tail}, 32'd1);
    push_entry(OP_LW, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd0, 4'd10);
    check("drop_tail", {28'd0, lsb_tail}, 32'd1);
    $display("fill/wrap tail=%0d full=%0d", lsb_tail, lsb_full);

    // Clear arriving with mem_done abandons the in-flight load.
    do_reset();
    push_entry(OP_LW, 1'b1, 32'h900, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd7);
    wait_req("abn_req");
    clear = 1'b1; mem_done = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    clear = 1'b0; mem_done = 1'b0;
    check("abn_req_drop", {31'd0, mem_req}, 32'd0);
    check("abn_no_out",   {31'd0, lsb_out_flag}, 32'd0);
    check("abn_tail",     {28'd0, lsb_tail}, 32'd0);
    tick();
    check("abn_no_out2",  {31'd0, lsb_out_flag}, 32'd0);
    check("abn_idle_req", {31'd0, mem_req}, 32'd0);
    push_entry(OP_LW, 1'b1, 32'hA00, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd8);
    wait_req("abn_next_req");
    check("abn_next_addr", mem_addr, 32'hA00);
    mem_complete(32'h5A5A);
    check("abn_next_val",    lsb_out_val, 32'h5A5A);
    check("abn_next_robpos", {28'd0, lsb_out_robpos}, 32'd8);
    $display("abandon then load addr=0x%08h", mem_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
- In-order circular queue of memory instructions between the issue stage, the reorder buffer and the memory controller.
- Loads execute at the queue head once their address operand is ready. The result goes back to the ROB, tagged with the load's ROB position.
- A store executes only after the ROB has committed it (store-commit pulse carrying its LSB position) and its operands are ready.
- Committed stores survive a pipeline clear; everything else is flushed.

Parameters:
- LSB_SIZE, 16, number of entries (power of 2)
- LSB_W, 4, log2(LSB_SIZE); entry index width
- ROB_W, 4, ROB position width
- OP_W, 6, opcode width (shared op encoding)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ready  in  1  global enable; low = hold all state and outputs
- clear  in  1  flush request from ROB (mispredict)
- lsb_full  out  1  high when count >= LSB_SIZE-1
- lsb_tail  out  LSB_W  index the next push will occupy (goes to ROB push_lsbpos)
- push  in  1  enqueue new instruction
- push_op  in  OP_W  LB/LH/LW/LBU/LHU/SB/SH/SW
- push_rs1_ok  in  1  rs1 value valid
- push_rs1_val  in  32  rs1 value
- push_rs1_rob  in  ROB_W  rs1 producer tag
- push_rs2_ok  in  1  rs2 value valid
- push_rs2_val  in  32  rs2 value
- push_rs2_rob  in  ROB_W  rs2 producer tag
- push_imm  in  32  sign-extended offset
- push_robpos  in  ROB_W  own ROB slot
- alu_flag  in  1  ALU broadcast valid
- alu_val  in  32  ALU broadcast value
- alu_robpos  in  ROB_W  ALU broadcast tag
- rob_store_flag  in  1  store commit pulse
- rob_store_lsbpos  in  LSB_W  committed store's entry
- mem_req  out  1  request to memory controller, held until mem_done
- mem_wr  out  1  1 = store
- mem_addr  out  32  rs1+imm
- mem_wdata  out  32  rs2 value
- mem_len  out  2  0 = byte, 1 = half, 3 = word
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  32  raw load data, low-aligned
- lsb_out_flag  out  1  load result valid (also the self-broadcast)
- lsb_out_val  out  32  extended load value
- lsb_out_robpos  out  ROB_W  load's ROB tag

Behaviour:
- Reset: head=tail=count=0, all entry valid/committed bits 0, state IDLE. mem_req, mem_wr, lsb_out_flag = 0; mem_addr, mem_wdata, lsb_out_val = 0; mem_len = 0.
- ready low: nothing changes, outputs hold. lsb_out_flag is still cleared after one cycle.
- Push: entry written at tail and tail wraps mod LSB_SIZE.
  - Operands are snooped in the same cycle. A not-ok operand whose tag matches alu_robpos (with alu_flag) or lsb_out_robpos (with lsb_out_flag) is captured as ok.
- Snoop: every cycle, each valid entry with a pending operand captures a matching ALU or LSB broadcast.
- Store commit: committed[rob_store_lsbpos] set on the pulse. The last_commit pointer is updated to that index.
- FSM IDLE -> WAIT_MEM when the head entry is valid and launchable:
  - load: rs1 ok;
  - store: committed and rs1, rs2 ok.
- On that transition mem_req=1 (registered, 1 cycle after the condition). Address is rs1+imm, mod 2^32. mem_len comes from op.
- WAIT_MEM -> IDLE on mem_done. The head entry is popped, head++ and count--.
  - For a load, lsb_out_flag=1 the next cycle.
  - lsb_out_val: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- lsb_out_flag is a single-cycle pulse. At most one memory op is in flight; loads issue strictly in queue order.
- Push and pop in the same cycle: count unchanged. A push while count == LSB_SIZE is dropped.
- Clear:
  - Uncommitted entries are invalidated.
  - tail := last_commit+1 if any committed store remains, else head; count is recomputed.
  - A load in WAIT_MEM is abandoned: mem_req drops, state goes IDLE, no lsb_out_flag.
  - A committed store in flight completes normally.
  - A clear simultaneous with push drops the push. A clear simultaneous with a store commit keeps the commit.
- lsb_full also covers the one-cycle push latency of the issue stage.

Decomposition:
- Op encodings, DATA/ROB/LSB widths and size constants go in the shared def header.
- Optional sub-module load_extend (combinational: op + raw -> extended value), reusable by an MMIO path.

Test Plan:
- Push LW, rs1 ok = 0x100, imm = 4; mem_done with rdata 0xDEADBEEF after 3 cycles -> mem_addr = 0x104, mem_len = 3, then lsb_out_flag with val 0xDEADBEEF and the pushed robpos.
- Push LB (rdata 0x80) and LBU (same) -> out 0xFFFFFF80, then 0x00000080.
- Push SW at index 0 with rs2 pending on tag 5 -> no mem_req until rob_store_flag(lsbpos = 0) and alu_flag(robpos = 5, val = 0x55). Then mem_wr = 1, wdata = 0x55.
- Store committed, followed by 2 loads; assert clear -> the store still executes and the loads never issue; tail = 1, count = 0 after the store completes.
- Fill 15 entries -> lsb_full = 1; pop one via mem_done -> lsb_full = 0. The tail index wraps from 15 to 0 correctly.
- Load in WAIT_MEM and clear in the same cycle as mem_done -> no lsb_out_flag; FSM is IDLE next cycle.
